count_ctrl: RTL and testbench
=============================

COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 SHALL provide parameter DEFAULT_LIMIT, default 14, terminal count used when LIMIT = 0.
REQ-002 SHALL provide port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port START  input  1  start a pass from IDLE, or resume from HOLD.
REQ-005 SHALL provide port STOP  input  1  pause from RUN, or abort from HOLD.
REQ-006 SHALL provide port LIMIT  input  4  terminal count, sampled only on start from IDLE.
REQ-007 SHALL provide port REPEAT  input  1  1 = auto-restart after terminal count; sampled every terminal cycle.
REQ-008 SHALL provide port Q  output  4  current count value, registered.
REQ-009 SHALL provide port BUSY  output  1  high in RUN and HOLD.
REQ-010 SHALL provide port DONE  output  1  one-cycle pulse on pass completion, registered.
REQ-011 SHALL provide port WRAPS  output  4  completed-pass count, saturating at 15.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, HOLD.
REQ-013 IDLE: Q = 0, BUSY = 0; START = 1 and STOP = 0 -> RUN, latch lim = (LIMIT == 0 ? DEFAULT_LIMIT : LIMIT), clear WRAPS, Q stays 0 on that edge.
REQ-014 Latency: START sampled at edge k -> Q = 1 after edge k+1.
REQ-015 RUN, Q != lim: Q <= Q + 1 each edge.
REQ-016 RUN, Q == lim: Q <= 0, DONE <= 1 for exactly one cycle, WRAPS <= WRAPS + 1 unless already 15.
REQ-017 Terminal edge with REPEAT = 1 -> stay RUN; with REPEAT = 0 -> IDLE.
REQ-018 RUN with STOP = 1 -> HOLD, Q frozen. STOP takes priority over the terminal action, so no DONE fires and WRAPS does not increment.
REQ-019 HOLD: Q, lim and WRAPS frozen, BUSY = 1; START = 1 and STOP = 0 -> RUN, counting resumes on the following edge.
REQ-020 HOLD with STOP = 1 -> IDLE, Q <= 0, no DONE (abort).
REQ-021 START and STOP both high: STOP wins in every state; in IDLE, no action.
REQ-022 START in RUN SHALL be ignored; LIMIT changes outside the IDLE-start edge SHALL be ignored.
REQ-023 Q SHALL never exceed lim; arithmetic is 4-bit unsigned. lim = 15 counts 0..15.
REQ-024 DONE SHALL be 0 in all cycles except the one following a terminal edge.

Reset
REQ-025 RESET = 1 at a rising edge SHALL force IDLE, Q = 0, DONE = 0, BUSY = 0, WRAPS = 0, lim = DEFAULT_LIMIT, overriding all other inputs.
REQ-026 Reset mid-RUN or mid-HOLD SHALL abort with no DONE pulse.
REQ-027 Between edges, RESET SHALL have no effect; there is no asynchronous path.

Structure
REQ-028 Package count_pkg SHALL hold the FSM state encoding (2-bit: IDLE = 0, RUN = 1, HOLD = 2) and the DEFAULT_LIMIT default value.
REQ-029 The count datapath SHALL be sub-module cnt4, a 4-bit register with sync clear, enable, and a terminal-compare output against lim.
REQ-030 count_ctrl SHALL contain the FSM, the lim and WRAPS registers, and output registering.

Verification
REQ-031 Basic pass: LIMIT = 5, REPEAT = 0, START pulse -> Q = 0,1,2,3,4,5,0; DONE high for one cycle when Q returns to 0; BUSY low afterwards; WRAPS = 1.
REQ-032 Default limit and repeat: LIMIT = 0, REPEAT = 1 for 3 passes -> Q wraps at 14 each pass, three DONE pulses 15 cycles apart, WRAPS = 3, BUSY stays high.
REQ-033 Pause/resume: STOP at Q = 7 -> Q holds 7 for N cycles; START -> Q = 8 on the next edge; pass completes normally.
REQ-034 Abort and priority: STOP in HOLD -> Q = 0, IDLE, no DONE; START and STOP together in RUN at Q = lim -> HOLD, no DONE, WRAPS unchanged.
REQ-035 Reset: RESET at Q = 9 with START also high -> next edge Q = 0, BUSY = 0, WRAPS = 0; no DONE in the following 16 cycles.
REQ-036 Saturation: LIMIT = 1, REPEAT = 1 for 20 passes -> WRAPS stays at 15; START while RUN has no effect; mid-run LIMIT change is ignored.

Source files
------------

// File: rtl/count_pkg.sv
// Shared definitions for the count_ctrl block: FSM state encoding,
// the default terminal count, and a saturating increment helper.
package count_pkg;

  // Terminal count used when LIMIT is 0 at pass start.
  localparam int unsigned DEFAULT_LIMIT_C = 14;

  // FSM state encoding, kept as plain 2-bit constants so external
  // checkers and older tools can match on raw values.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  // Completed-pass counter increment that sticks at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/count_ctrl_if.sv
// Control/status bundle of the count controller.
//
// Handshake: START and STOP are level-sampled commands, evaluated only at
// the rising clock edge; there is no valid/ready pairing because the
// controller accepts or ignores a command in the same cycle depending on
// its state. Q, BUSY, DONE and WRAPS are registered status outputs.
// dbg_state mirrors the FSM state register for observation.
interface count_ctrl_if;
  import count_pkg::*;

  logic       START;
  logic       STOP;
  logic [3:0] LIMIT;
  logic       REPEAT;
  logic [3:0] Q;
  logic       BUSY;
  logic       DONE;
  logic [3:0] WRAPS;
  state_t     dbg_state;

  // Driver side (bench or upstream controller).
  modport master (
    output START, STOP, LIMIT, REPEAT,
    input  Q, BUSY, DONE, WRAPS, dbg_state
  );

  // Counter side.
  modport slave (
    input  START, STOP, LIMIT, REPEAT,
    output Q, BUSY, DONE, WRAPS, dbg_state
  );

endinterface

// File: rtl/cnt4.sv
// 4-bit count register with synchronous clear and enable, plus a
// combinational compare against the latched terminal count.
module cnt4 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [3:0] lim_i,
  output logic [3:0] q_o,
  output logic       at_lim_o
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next count: clear wins over enable; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 4'd0;
    end else if (en_i) begin
      q_d = q_q + 4'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o      = q_q;
  assign at_lim_o = (q_q == lim_i);

endmodule

// File: rtl/count_ctrl.sv
// Start/stop/hold pass counter. Counts 0..lim per pass, pulses DONE after
// each completed pass, optionally auto-restarts, and tracks completed
// passes in a saturating WRAPS counter.
module count_ctrl
  import count_pkg::*;
#(
  parameter int unsigned DEFAULT_LIMIT = DEFAULT_LIMIT_C
) (
  input  logic         CLK,
  input  logic         RESET,
  count_ctrl_if.slave  bus
);

  localparam logic [3:0] DEF_LIM = 4'(DEFAULT_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] lim_q, lim_d;
  logic [3:0] wraps_q, wraps_d;
  logic       done_q, done_d;

  logic       cnt_clr;
  logic       cnt_en;
  logic       at_lim;
  logic [3:0] cnt_q;

  // FSM next-state and datapath control. STOP is tested before START and
  // before the terminal action so it always wins.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    wraps_d = wraps_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Keep the count pinned at 0 while idle.
        cnt_clr = 1'b1;
        if (bus.START && !bus.STOP) begin
          state_d = ST_RUN;
          lim_d   = (bus.LIMIT == 4'd0) ? DEF_LIM : bus.LIMIT;
          wraps_d = 4'd0;
        end
      end
      ST_RUN: begin
        if (bus.STOP) begin
          state_d = ST_HOLD;
        end else if (at_lim) begin
          cnt_clr = 1'b1;
          done_d  = 1'b1;
          wraps_d = sat_inc4(wraps_q);
          state_d = bus.REPEAT ? ST_RUN : ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.STOP) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (bus.START) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State, limit, pass counter and DONE registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      lim_q   <= DEF_LIM;
      wraps_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      wraps_q <= wraps_d;
      done_q  <= done_d;
    end
  end

  cnt4 u_cnt4 (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .lim_i    (lim_q),
    .q_o      (cnt_q),
    .at_lim_o (at_lim)
  );

  assign bus.Q         = cnt_q;
  assign bus.BUSY      = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign bus.DONE      = done_q;
  assign bus.WRAPS     = wraps_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: reset, basic pass, default limit with
// repeat, pause/resume, abort and STOP priority, mid-run reset, and
// WRAPS saturation.
module tb_count_ctrl;

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_pass;

  count_ctrl_if bus ();

  count_ctrl #(.DEFAULT_LIMIT(14)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] q, input logic busy,
                         input logic done, input logic [3:0] wraps);
    chk({tag, ".Q"},     bus.Q,     q);
    chk({tag, ".BUSY"},  {3'b0, bus.BUSY}, {3'b0, busy});
    chk({tag, ".DONE"},  {3'b0, bus.DONE}, {3'b0, done});
    chk({tag, ".WRAPS"}, bus.WRAPS, wraps);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    RESET      = 1'b1;
    bus.START  = 1'b0;
    bus.STOP   = 1'b0;
    bus.LIMIT  = 4'd0;
    bus.REPEAT = 1'b0;

    // Reset state
    step();
    step();
    chk_all("reset", 4'd0, 1'b0, 1'b0, 4'd0);
    RESET = 1'b0;

    // Basic pass, LIMIT=5
    bus.LIMIT = 4'd5;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    chk_all("basic_start", 4'd0, 1'b1, 1'b0, 4'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all("basic_cnt", 4'(i), 1'b1, 1'b0, 4'd0);
    end
    step();
    chk_all("basic_term", 4'd0, 1'b0, 1'b1, 4'd1);
    step();
    chk_all("basic_after", 4'd0, 1'b0, 1'b0, 4'd1);

    // Default limit (14) with repeat for three passes
    bus.LIMIT  = 4'd0;
    bus.REPEAT = 1'b1;
    bus.START  = 1'b1;
    step();
    bus.START = 1'b0;
    chk_all("dflt_start", 4'd0, 1'b1, 1'b0, 4'd0);
    for (int p = 1; p <= 3; p++) begin
      for (int i = 1; i <= 14; i++) begin
        step();
        chk_all("dflt_cnt", 4'(i), 1'b1, 1'b0, 4'(p - 1));
      end
      if (p == 3) bus.REPEAT = 1'b0;
      step();
      chk_all("dflt_term", 4'd0, (p != 3), 1'b1, 4'(p));
    end

    // Pause at 7, hold, resume, complete (LIMIT=9)
    bus.LIMIT = 4'd9;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    chk_all("pause_pre", 4'd7, 1'b1, 1'b0, 4'd0);
    bus.STOP = 1'b1;
    step();
    bus.STOP = 1'b0;
    chk_all("pause_stop", 4'd7, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("pause_hold", 4'd7, 1'b1, 1'b0, 4'd0);
    end
    bus.LIMIT = 4'd2;  // ignored outside the IDLE start edge
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    chk_all("resume_edge", 4'd7, 1'b1, 1'b0, 4'd0);
    step();
    chk_all("resume_8", 4'd8, 1'b1, 1'b0, 4'd0);
    step();
    chk_all("resume_9", 4'd9, 1'b1, 1'b0, 4'd0);
    step();
    chk_all("resume_term", 4'd0, 1'b0, 1'b1, 4'd1);

    // Abort from HOLD: no DONE, back to IDLE
    bus.LIMIT = 4'd3;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    step();
    chk_all("abort_cnt", 4'd1, 1'b1, 1'b0, 4'd0);
    bus.STOP = 1'b1;
    step();
    chk_all("abort_hold", 4'd1, 1'b1, 1'b0, 4'd0);
    step();
    bus.STOP = 1'b0;
    chk_all("abort_idle", 4'd0, 1'b0, 1'b0, 4'd0);
    step();
    chk_all("abort_after", 4'd0, 1'b0, 1'b0, 4'd0);

    // START+STOP at Q==lim in RUN: HOLD, no DONE, WRAPS unchanged
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    chk_all("prio_at_lim", 4'd3, 1'b1, 1'b0, 4'd0);
    bus.START = 1'b1;
    bus.STOP  = 1'b1;
    step();
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    chk_all("prio_hold", 4'd3, 1'b1, 1'b0, 4'd0);
    step();
    chk_all("prio_hold2", 4'd3, 1'b1, 1'b0, 4'd0);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    chk_all("prio_resume", 4'd3, 1'b1, 1'b0, 4'd0);
    step();
    chk_all("prio_term", 4'd0, 1'b0, 1'b1, 4'd1);

    // START+STOP in IDLE: no action
    bus.START = 1'b1;
    bus.STOP  = 1'b1;
    step();
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    chk_all("idle_both", 4'd0, 1'b0, 1'b0, 4'd1);

    // Reset at Q=9 with START high, after one completed pass
    bus.LIMIT  = 4'd12;
    bus.REPEAT = 1'b1;
    bus.START  = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 1; i <= 13; i++) step();
    chk_all("rst_pass1", 4'd0, 1'b1, 1'b1, 4'd1);
    for (int i = 1; i <= 9; i++) step();
    chk_all("rst_pre", 4'd9, 1'b1, 1'b0, 4'd1);
    RESET     = 1'b1;
    bus.START = 1'b1;
    step();
    RESET      = 1'b0;
    bus.START  = 1'b0;
    bus.REPEAT = 1'b0;
    chk_all("rst_edge", 4'd0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk({"rst_quiet.DONE"}, {3'b0, bus.DONE}, 4'd0);
      chk({"rst_quiet.Q"}, bus.Q, 4'd0);
    end

    // Saturation: LIMIT=1, repeat, 20 passes; START and LIMIT changes mid-run
    bus.LIMIT  = 4'd1;
    bus.REPEAT = 1'b1;
    bus.START  = 1'b1;
    step();
    bus.START = 1'b0;
    for (int p = 1; p <= 20; p++) begin
      if (p == 5) begin
        bus.START = 1'b1;
        bus.LIMIT = 4'd7;
      end
      if (p == 7) bus.START = 1'b0;
      step();
      chk_all("sat_cnt", 4'd1, 1'b1, 1'b0, 4'((p - 1) > 15 ? 15 : (p - 1)));
      step();
      chk_all("sat_term", 4'd0, 1'b1, 1'b1, 4'(p > 15 ? 15 : p));
    end
    bus.REPEAT = 1'b0;
    step();
    chk_all("sat_last_cnt", 4'd1, 1'b1, 1'b0, 4'd15);
    step();
    chk_all("sat_last_term", 4'd0, 1'b0, 1'b1, 4'd15);
    step();
    chk_all("sat_idle", 4'd0, 1'b0, 1'b0, 4'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
